adder_server: RTL and testbench

//  Shared-adder responder: serves the adder_inp1/adder_inp2 -> adder_out request side used by iterative

---
 rtl/adder_server_pkg.sv | 26 ++
 rtl/adder_server_arb.sv | 70 +++++++
 rtl/adder_server.sv | 150 +++++++++++++++
 tb/tb_adder_server.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/adder_server_pkg.sv
// -----------------------------------------------------------------------------
// adder_server_pkg
// Shared types and constants for the shared-adder responder.
//   - state_t      : FSM encoding (IDLE -> CALC -> RESP -> IDLE)
//   - DEFAULT_W    : default operand/result width
//   - MAX_CLIENTS  : largest supported number of requesters
//   - idx_width()  : width of a client index (never below 1 bit)
// No ports; imported by adder_server and adder_server_arb.
// -----------------------------------------------------------------------------
package adder_server_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_W   = 17;
  localparam int MAX_CLIENTS = 8;

  // A single client still needs a 1-bit index so every vector has a width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_server_arb.sv
// -----------------------------------------------------------------------------
// adder_server_arb
// Purely combinational arbiter choosing one requester per transaction.
// Configuration macro: ADDER_SERVER_RR_EN
//   defined   : round-robin, search starts at (ptr + 1) mod NUM_CLIENTS
//   undefined : fixed priority, lowest index wins, ptr is ignored
// Ports:
//   req        in  NUM_CLIENTS  request vector
//   ptr        in  IDX_W        index of the previous grant
//   grant      out NUM_CLIENTS  one-hot grant (all zero when no request)
//   grant_idx  out IDX_W        index of the granted client
//   grant_any  out 1            some client is granted
// -----------------------------------------------------------------------------
module adder_server_arb
  import adder_server_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_any
);

`ifdef ADDER_SERVER_RR_EN
  int unsigned cand;

  // Walk the clients starting just after the previous winner; the first
  // requester met in that rotated order wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = (int'(ptr) + 1 + i) % NUM_CLIENTS;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
        if (!grant_any && (cand == j) && req[j]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: the lowest-numbered requester wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      grant[j] = grant_any && (grant_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/adder_server.sv
// -----------------------------------------------------------------------------
// adder_server
// Shared-adder responder: arbitrates NUM_CLIENTS requesters and performs one
// W-bit add (carry discarded) per grant, three cycles per transaction.
// Clients subtract by sending the two's-complement operand themselves.
// Configuration macro: ADDER_SERVER_RR_EN (round-robin arbitration when
// defined, fixed lowest-index priority otherwise).
// Parameters: NUM_CLIENTS (1..8), W (operand/result width).
// Ports:
//   clk_i   in  1              clock, rising edge
//   rst_i   in  1              asynchronous active-high reset
//   req_bi  in  NUM_CLIENTS    per-client request, held until ack
//   a_bi    in  NUM_CLIENTS*W  operand A, client k at [k*W +: W]
//   b_bi    in  NUM_CLIENTS*W  operand B, same packing
//   y_bo    out W              registered sum, valid while ack_bo is high
//   ack_bo  out NUM_CLIENTS    one-hot single-cycle ack to the served client
//   busy_o  out 1              high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module adder_server
  import adder_server_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int W           = DEFAULT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CLIENTS-1:0]   req_bi,
  input  logic [NUM_CLIENTS*W-1:0] a_bi,
  input  logic [NUM_CLIENTS*W-1:0] b_bi,
  output logic [W-1:0]             y_bo,
  output logic [NUM_CLIENTS-1:0]   ack_bo,
  output logic                     busy_o
);

  localparam int IDX_W = idx_width(NUM_CLIENTS);

  state_t                 state, next_state;
  logic [IDX_W-1:0]       grant_idx_q;
  logic [W-1:0]           a_lat, b_lat;
  logic [W-1:0]           a_sel, b_sel;
  logic [NUM_CLIENTS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [IDX_W-1:0]       arb_ptr;
  logic [NUM_CLIENTS-1:0] ack_set;

`ifdef ADDER_SERVER_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  // Remember the last winner so the next search begins after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (state == ST_IDLE && arb_any) begin
      rr_ptr <= arb_idx;
    end
  end

  assign arb_ptr = rr_ptr;
`else
  assign arb_ptr = '0;
`endif

  adder_server_arb #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req       (req_bi),
    .ptr       (arb_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Pick the winner's operands out of the flattened buses.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      if (arb_grant[j]) begin
        a_sel = a_bi[j*W +: W];
        b_sel = b_bi[j*W +: W];
      end
    end
  end

  always_comb begin
    ack_set = '0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      ack_set[j] = (grant_idx_q == IDX_W'(j));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Requests are only looked at in IDLE; RESP always returns to IDLE so a
  // still-high request is treated as a fresh one on the following edge.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (arb_any) next_state = ST_CALC;
      ST_CALC: next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != ST_IDLE);
  end

  // Operands are captured once at the grant so later changes on the bus do
  // not disturb the sum; y_bo keeps its value until the next CALC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_idx_q <= '0;
      a_lat       <= '0;
      b_lat       <= '0;
      y_bo        <= '0;
      ack_bo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_idx_q <= arb_idx;
            a_lat       <= a_sel;
            b_lat       <= b_sel;
          end
        end
        ST_CALC: begin
          y_bo   <= a_lat + b_lat;
          ack_bo <= ack_set;
        end
        ST_RESP: begin
          ack_bo <= '0;
        end
        default: begin
          ack_bo <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_server.sv
// -----------------------------------------------------------------------------
// tb_adder_server
// Directed self-checking bench for adder_server (W=17, NUM_CLIENTS=2).
// Inputs change and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adder_server;

  logic        clk;
  logic        rst;
  logic [1:0]  req_bi;
  logic [33:0] a_bi;
  logic [33:0] b_bi;
  logic [16:0] y_bo;
  logic [1:0]  ack_bo;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [1:0]  cont_ack [3];
  logic [16:0] exp_y;

  adder_server #(
    .NUM_CLIENTS (2),
    .W           (17)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_bi (req_bi),
    .a_bi   (a_bi),
    .b_bi   (b_bi),
    .y_bo   (y_bo),
    .ack_bo (ack_bo),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] req,
                               input logic [16:0] a0, input logic [16:0] b0,
                               input logic [16:0] a1, input logic [16:0] b1);
    req_bi = req;
    a_bi   = {a1, a0};
    b_bi   = {b1, b0};
  endtask

  task automatic checkOutput(input string tag, input logic [16:0] ey,
                             input logic [1:0] eack, input logic ebusy);
    checks++;
    assert (y_bo === ey) else begin
      errors++;
      $error("[TB] FAIL %s y_bo observed %0d expected %0d", tag, y_bo, ey);
    end
    checks++;
    assert (ack_bo === eack) else begin
      errors++;
      $error("[TB] FAIL %s ack_bo observed %b expected %b", tag, ack_bo, eack);
    end
    checks++;
    assert (busy_o === ebusy) else begin
      errors++;
      $error("[TB] FAIL %s busy_o observed %b expected %b", tag, busy_o, ebusy);
    end
  endtask

  initial begin
`ifdef ADDER_SERVER_RR_EN
    cont_ack[0] = 2'b01;
    cont_ack[1] = 2'b10;
    cont_ack[2] = 2'b01;
`else
    cont_ack[0] = 2'b01;
    cont_ack[1] = 2'b01;
    cont_ack[2] = 2'b01;
`endif

    rst = 1'b1;
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("reset", 17'd0, 2'b00, 1'b0);
    rst = 1'b0;

    // Single add: 100 + (-64) = 36; operands scrambled after the latch.
    applyStimulus(2'b01, 17'd100, 17'h1FFC0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t1_calc", 17'd0, 2'b00, 1'b1);
    applyStimulus(2'b01, 17'h00555, 17'h00AAA, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t1_resp", 17'd36, 2'b01, 1'b1);
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t1_idle", 17'd36, 2'b00, 1'b0);

    // Wrap: 0x1FFFF + 1 loses the carry.
    applyStimulus(2'b10, 17'd0, 17'd0, 17'h1FFFF, 17'd1);
    @(negedge clk);
    checkOutput("t2_calc", 17'd36, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("t2_resp", 17'd0, 2'b10, 1'b1);
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t2_idle", 17'd0, 2'b00, 1'b0);

    // Contention: client0 sums to 15, client1 to 1000 - 2 = 998.
    applyStimulus(2'b11, 17'd10, 17'd5, 17'd1000, 17'h1FFFE);
    exp_y = 17'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_calc%0d", k), exp_y, 2'b00, 1'b1);
      exp_y = (cont_ack[k] == 2'b01) ? 17'd15 : 17'd998;
      @(negedge clk);
      checkOutput($sformatf("t3_resp%0d", k), exp_y, cont_ack[k], 1'b1);
      @(negedge clk);
      checkOutput($sformatf("t3_idle%0d", k), exp_y, 2'b00, 1'b0);
    end
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);

    // Back-to-back: re-request in the first IDLE after the ack.
    applyStimulus(2'b01, 17'd7, 17'd9, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t4_calc_a", 17'd15, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("t4_resp_a", 17'd16, 2'b01, 1'b1);
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t4_idle_a", 17'd16, 2'b00, 1'b0);
    applyStimulus(2'b01, 17'd300, 17'd200, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t4_calc_b", 17'd16, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("t4_resp_b", 17'd500, 2'b01, 1'b1);
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t4_idle_b", 17'd500, 2'b00, 1'b0);

    // Asynchronous reset while in CALC; the request never gets an ack.
    applyStimulus(2'b10, 17'd0, 17'd0, 17'd3, 17'd4);
    @(negedge clk);
    checkOutput("t5_calc", 17'd500, 2'b00, 1'b1);
    #2 rst = 1'b1;
    #1 checkOutput("t5_rst", 17'd0, 2'b00, 1'b0);
    #1 rst = 1'b0;
    applyStimulus(2'b00, 17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t5_after1", 17'd0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("t5_after2", 17'd0, 2'b00, 1'b0);

    // Withdrawn request: pulled low before the grant edge.
    applyStimulus(2'b01, 17'd11, 17'd22, 17'd0, 17'd0);
    #2 applyStimulus(2'b00, 17'd11, 17'd22, 17'd0, 17'd0);
    @(negedge clk);
    checkOutput("t6_idle1", 17'd0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("t6_idle2", 17'd0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
